// File: rtl/mxv_sequencer.sv
// -----------------------------------------------------------------------------
// mxv_sequencer
//
// Control sequencer for the matrix-vector multiply datapath. It walks the
// stored NxN matrix row by row. For each row it issues one storage read
// address per column, then steers the MAC through clear/accumulate. It then
// presents the row result to the transmitter with a valid/ready handshake.
//
// Parameters
//   WORD_LENGTH  datapath element width; not used here, kept for the datapath
//   MAX_N        largest legal matrix dimension
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   cfg_valid  in   one-cycle strobe, cfg_size is sampled (IDLE only)
//   cfg_size   in   matrix dimension N, legal range 1..MAX_N
//   start      in   one-cycle strobe, begins a multiply (IDLE only)
//   mat_addr   out  matrix read address, row*MAX_N+col
//   vec_addr   out  vector read address, col
//   mac_clear  out  clears the accumulator (first column of each row)
//   mac_en     out  accumulates the product read in the previous cycle
//   res_valid  out  row result available on the datapath output
//   res_row    out  row index of the presented result
//   res_ready  in   transmitter accepts the result
//   busy       out  sequence in progress
//   done       out  one-cycle pulse after the last row is transferred
//   err        out  one-cycle pulse on illegal cfg or unconfigured start
//   abort      in   (MXV_SEQ_ABORT_EN only) forces IDLE from any busy state
//
// Optional feature macro: MXV_SEQ_ABORT_EN
// All outputs are registered.
// -----------------------------------------------------------------------------
module mxv_sequencer #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned MAX_N       = 8,
    localparam int unsigned IDX_W      = $clog2(MAX_N),
    localparam int unsigned SIZE_W     = $clog2(MAX_N + 1),
    localparam int unsigned ADDR_W     = $clog2(MAX_N * MAX_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [SIZE_W-1:0] cfg_size,
    input  logic              start,
`ifdef MXV_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] mat_addr,
    output logic [IDX_W-1:0]  vec_addr,
    output logic              mac_clear,
    output logic              mac_en,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_row,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]        state,     state_d;
    logic [SIZE_W-1:0] n_reg,     n_reg_d;
    // Run length latched at start, so a cfg in the start cycle cannot
    // disturb the sequence it launches.
    logic [SIZE_W-1:0] n_run,     n_run_d;
    logic [IDX_W-1:0]  row,       row_d;
    logic [IDX_W-1:0]  col,       col_d;
    logic [ADDR_W-1:0] mat_addr_d;
    logic [IDX_W-1:0]  vec_addr_d;
    logic              mac_clear_d;
    logic              mac_en_d;
    logic              res_valid_d;
    logic [IDX_W-1:0]  res_row_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;

    logic              cfg_legal_c;
    logic              last_col_c;
    logic              last_row_c;

    // Parameter is only carried for the datapath
    logic [31:0] word_length_unused;
    assign word_length_unused = 32'(WORD_LENGTH);

    // Matrix storage address of element (r, c)
    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c);
        return ADDR_W'(ADDR_W'(r) * ADDR_W'(MAX_N)) + ADDR_W'(c);
    endfunction

    assign cfg_legal_c = (cfg_size != '0) && (cfg_size <= SIZE_W'(MAX_N));
    assign last_col_c  = (SIZE_W'(col) == (n_run - SIZE_W'(1)));
    assign last_row_c  = (SIZE_W'(row) == (n_run - SIZE_W'(1)));

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        n_reg_d     = n_reg;
        n_run_d     = n_run;
        row_d       = row;
        col_d       = col;
        mat_addr_d  = mat_addr;
        vec_addr_d  = vec_addr;
        mac_clear_d = 1'b0;
        mac_en_d    = 1'b0;
        res_valid_d = 1'b0;
        res_row_d   = res_row;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state)
            S_IDLE: begin
                // Both strobes may arrive together; start sees the old n_reg
                if (cfg_valid) begin
                    if (cfg_legal_c) begin
                        n_reg_d = cfg_size;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (start) begin
                    if (n_reg == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        n_run_d     = n_reg;
                        row_d       = '0;
                        col_d       = '0;
                        mat_addr_d  = '0;
                        vec_addr_d  = '0;
                        mac_clear_d = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                // Read issued this cycle returns next cycle: accumulate then
                mac_en_d = 1'b1;
                if (last_col_c) begin
                    state_d = S_DRAIN;
                end else begin
                    col_d      = col + IDX_W'(1);
                    mat_addr_d = addr_of(row, col + IDX_W'(1));
                    vec_addr_d = col + IDX_W'(1);
                end
            end

            S_DRAIN: begin
                state_d     = S_OUTPUT;
                res_valid_d = 1'b1;
                res_row_d   = row;
            end

            S_OUTPUT: begin
                res_valid_d = 1'b1;
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    col_d       = '0;
                    if (last_row_c) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        row_d       = row + IDX_W'(1);
                        mat_addr_d  = addr_of(row + IDX_W'(1), '0);
                        vec_addr_d  = '0;
                        mac_clear_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                row_d   = '0;
                col_d   = '0;
            end
        endcase

`ifdef MXV_SEQ_ABORT_EN
        // Abort drops the sequence without a done pulse; n_reg survives
        if (abort && (state != S_IDLE)) begin
            state_d     = S_IDLE;
            row_d       = '0;
            col_d       = '0;
            mat_addr_d  = mat_addr;
            vec_addr_d  = vec_addr;
            mac_clear_d = 1'b0;
            mac_en_d    = 1'b0;
            res_valid_d = 1'b0;
            res_row_d   = res_row;
            done_d      = 1'b0;
            err_d       = 1'b0;
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            n_reg     <= '0;
            n_run     <= '0;
            row       <= '0;
            col       <= '0;
            mat_addr  <= '0;
            vec_addr  <= '0;
            mac_clear <= 1'b0;
            mac_en    <= 1'b0;
            res_valid <= 1'b0;
            res_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            n_reg     <= n_reg_d;
            n_run     <= n_run_d;
            row       <= row_d;
            col       <= col_d;
            mat_addr  <= mat_addr_d;
            vec_addr  <= vec_addr_d;
            mac_clear <= mac_clear_d;
            mac_en    <= mac_en_d;
            res_valid <= res_valid_d;
            res_row   <= res_row_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mxv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mxv_sequencer
//
// Self-checking bench for mxv_sequencer. A per-cycle expected trace is built
// from the sequencing rules (n address cycles, one drain, one or more output
// cycles per row, then done) and compared against the DUT on every falling
// edge. Random N, random output stalls, random res_ready outside OUTPUT and
// random cfg/start noise while busy exercise the handshake and ignore rules.
// -----------------------------------------------------------------------------
module tb_mxv_sequencer;

    localparam int unsigned MAX_N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [3:0] cfg_size;
    logic       start;
    logic [5:0] mat_addr;
    logic [2:0] vec_addr;
    logic       mac_clear;
    logic       mac_en;
    logic       res_valid;
    logic [2:0] res_row;
    logic       res_ready;
    logic       busy;
    logic       done;
    logic       err;
`ifdef MXV_SEQ_ABORT_EN
    logic       abort;
`endif

    mxv_sequencer #(.WORD_LENGTH(8), .MAX_N(MAX_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_size  (cfg_size),
        .start     (start),
`ifdef MXV_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .mat_addr  (mat_addr),
        .vec_addr  (vec_addr),
        .mac_clear (mac_clear),
        .mac_en    (mac_en),
        .res_valid (res_valid),
        .res_row   (res_row),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] mat_addr;
        logic [2:0] vec_addr;
        logic       addr_chk;
        logic       mac_clear;
        logic       mac_en;
        logic       res_valid;
        logic [2:0] res_row;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fails   = 0;
    int   n_model   = 0;
    int   busy_seen = 0;
    int   st[MAX_N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected trace of one full run: per row n issue cycles, one drain,
    // stall+1 output cycles; then the done cycle.
    task automatic build(input int n, input int stall[MAX_N]);
        exp_t e;
        exp_q.delete();
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                e.mat_addr  = 6'(r * MAX_N + c);
                e.vec_addr  = 3'(c);
                e.addr_chk  = 1'b1;
                e.mac_clear = (c == 0);
                e.mac_en    = (c != 0);
                e.res_valid = 1'b0;
                e.res_row   = 3'(r);
                e.busy      = 1'b1;
                e.done      = 1'b0;
                e.ready     = 1'($urandom);
                exp_q.push_back(e);
            end
            e.addr_chk  = 1'b0;
            e.mac_clear = 1'b0;
            e.mac_en    = 1'b1;
            e.ready     = 1'($urandom);
            exp_q.push_back(e);
            for (int k = 0; k <= stall[r]; k++) begin
                e.mac_en    = 1'b0;
                e.res_valid = 1'b1;
                e.ready     = (k == stall[r]);
                exp_q.push_back(e);
            end
        end
        e.addr_chk  = 1'b0;
        e.mac_clear = 1'b0;
        e.mac_en    = 1'b0;
        e.res_valid = 1'b0;
        e.busy      = 1'b0;
        e.done      = 1'b1;
        e.ready     = 1'($urandom);
        exp_q.push_back(e);
    endtask

    // Compare the first 'upto' trace entries, injecting noise while busy
    task automatic run_expect(input int upto);
        exp_t e;
        for (int i = 0; i < upto && i < exp_q.size(); i++) begin
            e = exp_q[i];
            @(negedge clk);
            start     = 1'b0;
            cfg_valid = 1'b0;
            if (busy === 1'b1) busy_seen++;
            check($sformatf("c%0d busy", i),      32'(busy),      32'(e.busy));
            check($sformatf("c%0d mac_en", i),    32'(mac_en),    32'(e.mac_en));
            check($sformatf("c%0d mac_clear", i), 32'(mac_clear), 32'(e.mac_clear));
            check($sformatf("c%0d res_valid", i), 32'(res_valid), 32'(e.res_valid));
            check($sformatf("c%0d done", i),      32'(done),      32'(e.done));
            check($sformatf("c%0d err", i),       32'(err),       32'(0));
            if (e.addr_chk) begin
                check($sformatf("c%0d mat_addr", i), 32'(mat_addr), 32'(e.mat_addr));
                check($sformatf("c%0d vec_addr", i), 32'(vec_addr), 32'(e.vec_addr));
            end
            if (e.res_valid) begin
                check($sformatf("c%0d res_row", i), 32'(res_row), 32'(e.res_row));
            end
            res_ready = e.ready;
            if (e.busy) begin
                start     = (($urandom % 4) == 0);
                cfg_valid = (($urandom % 4) == 0);
                cfg_size  = 4'($urandom);
            end
        end
    endtask

    task automatic do_run(input int n, input int stall[MAX_N], input bit cfg_too, input int cfg_sz);
        int total;
        @(negedge clk);
        start     = 1'b1;
        cfg_valid = cfg_too;
        cfg_size  = 4'(cfg_sz);
        build(n, stall);
        busy_seen = 0;
        run_expect(exp_q.size());
        total = n * (n + 2);
        for (int r = 0; r < n; r++) total += stall[r];
        check($sformatf("busy_cycles n=%0d", n), 32'(busy_seen), 32'(total));
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b0;
        check("post_run done", 32'(done), 32'(0));
        check("post_run busy", 32'(busy), 32'(0));
    endtask

    task automatic cfg(input int sz);
        bit legal;
        legal = (sz >= 1) && (sz <= MAX_N);
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b1;
        cfg_size  = 4'(sz);
        @(negedge clk);
        cfg_valid = 1'b0;
        check($sformatf("cfg%0d err", sz), 32'(err), 32'(!legal));
        check($sformatf("cfg%0d busy", sz), 32'(busy), 32'(0));
        if (legal) n_model = sz;
    endtask

    task automatic start_unconfigured(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " err"}, 32'(err), 32'(1));
        check({tag, " busy"}, 32'(busy), 32'(0));
        @(negedge clk);
        check({tag, " err_clr"}, 32'(err), 32'(0));
        check({tag, " busy2"}, 32'(busy), 32'(0));
    endtask

    task automatic clear_stalls();
        for (int r = 0; r < MAX_N; r++) st[r] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mat_addr"},  32'(mat_addr),  32'(0));
        check({tag, " vec_addr"},  32'(vec_addr),  32'(0));
        check({tag, " mac_clear"}, 32'(mac_clear), 32'(0));
        check({tag, " mac_en"},    32'(mac_en),    32'(0));
        check({tag, " res_valid"}, 32'(res_valid), 32'(0));
        check({tag, " res_row"},   32'(res_row),   32'(0));
        check({tag, " busy"},      32'(busy),      32'(0));
        check({tag, " done"},      32'(done),      32'(0));
        check({tag, " err"},       32'(err),       32'(0));
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_size  = '0;
        start     = 1'b0;
        res_ready = 1'b0;
`ifdef MXV_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Unconfigured start and illegal sizes
        start_unconfigured("start_nocfg");
        cfg(0);
        cfg(9);
        start_unconfigured("start_after_bad_cfg");

        // N=3, ready always high
        cfg(3);
        clear_stalls();
        do_run(n_model, st, 1'b0, 0);

        // Illegal cfg keeps N=3; row 0 output stalled 4 cycles
        cfg(9);
        st[0] = 4;
        do_run(n_model, st, 1'b0, 0);

        // Largest and smallest sizes
        cfg(8);
        clear_stalls();
        do_run(n_model, st, 1'b0, 0);
        cfg(1);
        do_run(n_model, st, 1'b0, 0);

        // cfg together with start: run uses old N=1, next run uses N=2
        do_run(1, st, 1'b1, 2);
        n_model = 2;
        do_run(n_model, st, 1'b0, 0);

        // Random sizes and stall patterns
        for (int t = 0; t < 8; t++) begin
            n = int'($urandom_range(1, MAX_N));
            cfg(n);
            for (int r = 0; r < MAX_N; r++)
                st[r] = ($urandom % 2) ? int'($urandom_range(1, 3)) : 0;
            do_run(n_model, st, 1'b0, 0);
        end

        // Reset during row 1 issue
        cfg(3);
        clear_stalls();
        @(negedge clk);
        start = 1'b1;
        build(3, st);
        run_expect(3 + 2 + 2);
        reset     = 1'b1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("mid_reset");
        n_model = 0;
        @(negedge clk);
        check_all_zero("mid_reset2");
        start_unconfigured("start_after_reset");

`ifdef MXV_SEQ_ABORT_EN
        // Abort during row 0 drain, then rerun with retained N
        cfg(3);
        clear_stalls();
        @(negedge clk);
        start = 1'b1;
        build(3, st);
        run_expect(3 + 1);
        start     = 1'b0;
        cfg_valid = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy",      32'(busy),      32'(0));
        check("abort mac_en",    32'(mac_en),    32'(0));
        check("abort res_valid", 32'(res_valid), 32'(0));
        check("abort done",      32'(done),      32'(0));
        @(negedge clk);
        check("abort done2",     32'(done),      32'(0));
        do_run(n_model, st, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
